// File: rtl/aes_mixcol_pipe.sv
// aes_mixcol_pipe: two-stage pipelined AES MixColumns over LANES 32-bit columns.
// S1 registers the raw column bytes and their xtime products. S2 registers the
// finished column and drives the output handshake.
// Optional build macro AES_INV_MIX_EN adds the in_inv port and InvMixColumns.
// Without the macro, only the forward transform is built.

// Per-column datapath. It produces the xtime products for S1 capture, and the
// final column from the S1 contents.
module aes_mixcol_lane (
  input  logic [31:0] a_i,       // raw column about to enter S1
  output logic [31:0] x2_o,      // xtime of each byte of a_i
  input  logic [31:0] s1_a_i,    // column bytes held in S1
  input  logic [31:0] s1_x2_i,   // xtime products held in S1
`ifdef AES_INV_MIX_EN
  input  logic        s1_inv_i,  // 1 = InvMixColumns for this beat
`endif
  output logic [31:0] b_o
);
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  logic [3:0][7:0] ain, x2in, a, x2, fwd;

  assign ain = a_i;
  assign a   = s1_a_i;
  assign x2  = s1_x2_i;

  // Byte j of a column sits at bits [8j+7:8j]. Rotations are resolved at elaboration.
  for (genvar j = 0; j < 4; j++) begin : g_fwd
    assign x2in[j] = xtime(ain[j]);
    // 2a_j ^ 3a_{j+1} ^ a_{j+2} ^ a_{j+3}
    assign fwd[j]  = x2[j] ^ x2[(j+1)%4] ^ a[(j+1)%4] ^ a[(j+2)%4] ^ a[(j+3)%4];
  end

  assign x2_o = x2in;

`ifdef AES_INV_MIX_EN
  logic [3:0][7:0] x4, x8, m9, mb, md, me, inv;

  // Inverse coefficients are built from the chained doublings x2 -> x4 -> x8.
  for (genvar j = 0; j < 4; j++) begin : g_inv
    assign x4[j]  = xtime(x2[j]);
    assign x8[j]  = xtime(x4[j]);
    assign m9[j]  = x8[j] ^ a[j];
    assign mb[j]  = m9[j] ^ x2[j];
    assign md[j]  = m9[j] ^ x4[j];
    assign me[j]  = x8[j] ^ x4[j] ^ x2[j];
    assign inv[j] = me[j] ^ mb[(j+1)%4] ^ md[(j+2)%4] ^ m9[(j+3)%4];
  end

  assign b_o = s1_inv_i ? inv : fwd;
`else
  assign b_o = fwd;
`endif
endmodule

module aes_mixcol_pipe #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]      in_tag,
`ifdef AES_INV_MIX_EN
  input  logic                  in_inv,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]      out_tag
);
  typedef struct packed {
    logic [LANES-1:0][31:0] a;
    logic [LANES-1:0][31:0] x2;
    logic [TAG_W-1:0]       tag;
`ifdef AES_INV_MIX_EN
    logic                   inv;
`endif
  } s1_t;

  logic [2:1]             vld_pipe_q, vld_pipe_d;
  s1_t                    s1_q, s1_d;
  logic [LANES-1:0][31:0] x2_in, res, out_data_q, out_data_d;
  logic [TAG_W-1:0]       out_tag_q, out_tag_d;
  logic                   in_fire, out_fire, s2_adv;

  assign out_fire = vld_pipe_q[2] & out_ready;
  assign s2_adv   = vld_pipe_q[1] & (!vld_pipe_q[2] | out_ready);
  assign in_ready = !vld_pipe_q[1] | s2_adv;
  assign in_fire  = in_valid & in_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    aes_mixcol_lane u_lane (
      .a_i      (in_data[32*k +: 32]),
      .x2_o     (x2_in[k]),
      .s1_a_i   (s1_q.a[k]),
      .s1_x2_i  (s1_q.x2[k]),
`ifdef AES_INV_MIX_EN
      .s1_inv_i (s1_q.inv),
`endif
      .b_o      (res[k])
    );
  end

  // Stage advance: S2 refills from S1 when it is empty or draining. S1 refills when it is empty or advancing.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    if (in_fire) begin
      vld_pipe_d[1] = 1'b1;
      s1_d.a        = in_data;
      s1_d.x2       = x2_in;
      s1_d.tag      = in_tag;
`ifdef AES_INV_MIX_EN
      s1_d.inv      = in_inv;
`endif
    end else if (s2_adv) begin
      vld_pipe_d[1] = 1'b0;
    end
    if (s2_adv) begin
      vld_pipe_d[2] = 1'b1;
      out_data_d    = res;
      out_tag_d     = s1_q.tag;
    end else if (out_fire) begin
      vld_pipe_d[2] = 1'b0;
    end
  end

  // Pipeline registers. Reset drops every in-flight beat and zeroes the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
endmodule

// File: tb/tb_aes_mixcol_pipe.sv
// Directed bench for aes_mixcol_pipe. It runs a LANES=4 instance and a LANES=1
// instance side by side. Both instances share the handshake controls.
module tb_aes_mixcol_pipe;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, out_data;
  logic [3:0]   in_tag, out_tag;
  logic         in_ready1, out_valid1;
  logic [31:0]  d1_in, out_data1;
  logic [3:0]   out_tag1;
`ifdef AES_INV_MIX_EN
  logic         in_inv;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_mixcol_pipe #(.LANES(4), .TAG_W(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag),
`ifdef AES_INV_MIX_EN
    .in_inv(in_inv),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  aes_mixcol_pipe #(.LANES(1), .TAG_W(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(d1_in), .in_tag(in_tag),
`ifdef AES_INV_MIX_EN
    .in_inv(in_inv),
`endif
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_tag(out_tag1)
  );

  // Known MixColumns column pairs, with byte a0 in the least significant position.
  function automatic logic [31:0] vin(input int n);
    case (n % 6)
      0: return 32'h455313DB;
      1: return 32'h5C220AF2;
      2: return 32'h01010101;
      3: return 32'hC6C6C6C6;
      4: return 32'hD5D4D4D4;
      default: return 32'h4C31262D;
    endcase
  endfunction

  function automatic logic [31:0] vout(input int n);
    case (n % 6)
      0: return 32'hBCA14D8E;
      1: return 32'h9D58DC9F;
      2: return 32'h01010101;
      3: return 32'hC6C6C6C6;
      4: return 32'hD6D7D5D5;
      default: return 32'hF8BD7E4D;
    endcase
  endfunction

  function automatic logic [127:0] beat_in(input int i);
    return {vin(i+3), vin(i+2), vin(i+1), vin(i)};
  endfunction

  function automatic logic [127:0] beat_out(input int i);
    return {vout(i+3), vout(i+2), vout(i+1), vout(i)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; d1_in = '0; in_tag = '0;
`ifdef AES_INV_MIX_EN
    in_inv = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    checks++; if (out_valid1 !== 1'b0 || out_data1 !== 32'h0) begin
      errors++; $display("FAIL reset_lane1 got v=%b d=%h want v=0 d=0", out_valid1, out_data1); end
  endtask

  task automatic test_fwd_lane1();
    in_valid = 1'b1; d1_in = 32'h455313DB; in_data = beat_in(0); in_tag = 4'h3;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL lane1_early_valid got %b want 0", out_valid1); end
    tick();
    checks++; if (out_valid1 !== 1'b1 || out_data1 !== 32'hBCA14D8E || out_tag1 !== 4'h3) begin
      errors++; $display("FAIL lane1_fwd got v=%b d=%h t=%h want v=1 d=bca14d8e t=3", out_valid1, out_data1, out_tag1); end
    tick();
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL lane1_dup got %b want 0", out_valid1); end
  endtask

  task automatic test_fwd_lanes4();
    in_valid = 1'b1; in_tag = 4'hA; d1_in = 32'h0;
    in_data = {32'h01010101, 32'hC6C6C6C6, 32'h5C220AF2, 32'h455313DB};
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_tag !== 4'hA ||
                  out_data !== {32'h01010101, 32'hC6C6C6C6, 32'h9D58DC9F, 32'hBCA14D8E}) begin
      errors++; $display("FAIL lanes4_fwd got v=%b t=%h d=%h want v=1 t=a d=01010101c6c6c6c69d58dc9fbca14d8e",
                         out_valid, out_tag, out_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 11; c++) begin
      in_valid = (c < 8); in_data = beat_in(c); d1_in = vin(c); in_tag = 4'(c);
      #1;
      if (c < 8) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc=%0d got %b want 1", c, in_ready); end
      end
      checks++; if (out_valid !== (c >= 2 && c < 10)) begin
        errors++; $display("FAIL b2b_out_valid cyc=%0d got %b want %b", c, out_valid, (c >= 2 && c < 10)); end
      if (c >= 2 && c < 10) begin
        checks++; if (out_data !== beat_out(c-2) || out_tag !== 4'(c-2)) begin
          errors++; $display("FAIL b2b_data cyc=%0d got %h/%h want %h/%h", c, out_data, out_tag, beat_out(c-2), 4'(c-2)); end
        checks++; if (out_data1 !== vout(c-2)) begin
          errors++; $display("FAIL b2b_lane1 cyc=%0d got %h want %h", c, out_data1, vout(c-2)); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int ptr;
    int idx;
    bit exp_v;
    ptr = 0;
    for (int c = 0; c < 11; c++) begin
      out_ready = (c >= 5);
      in_valid = (ptr < 3); in_data = beat_in(ptr + 1); d1_in = vin(ptr + 1); in_tag = 4'(ptr + 4);
      #1;
      checks++; if (in_ready !== !(c >= 2 && c < 5)) begin
        errors++; $display("FAIL bp_in_ready cyc=%0d got %b want %b", c, in_ready, !(c >= 2 && c < 5)); end
      exp_v = (c >= 2 && c <= 7);
      idx = (c <= 5) ? 0 : c - 5;
      checks++; if (out_valid !== exp_v) begin
        errors++; $display("FAIL bp_out_valid cyc=%0d got %b want %b", c, out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (out_data !== beat_out(idx + 1) || out_tag !== 4'(idx + 4)) begin
          errors++; $display("FAIL bp_data cyc=%0d got %h/%h want %h/%h", c, out_data, out_tag, beat_out(idx + 1), 4'(idx + 4)); end
      end
      if (in_valid && in_ready) ptr++;
      tick();
    end
    checks++; if (ptr != 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", ptr); end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = beat_in(2); d1_in = vin(2); in_tag = 4'h7;
    tick();
    in_data = beat_in(3); d1_in = vin(3); in_tag = 4'h8;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_loaded got %b want 1", out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_data !== 128'h0 || out_tag !== 4'h0) begin
      errors++; $display("FAIL mid_reset got v=%b d=%h t=%h want v=0 d=0 t=0", out_valid, out_data, out_tag); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || out_valid1 !== 1'b0) begin
        errors++; $display("FAIL mid_stale cyc=%0d got %b/%b want 0/0", c, out_valid, out_valid1); end
    end
  endtask

`ifdef AES_INV_MIX_EN
  task automatic test_inverse();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 6); in_inv = c[0];
      in_data = c[0] ? beat_out(c) : beat_in(c);
      d1_in   = c[0] ? vout(c) : vin(c);
      in_tag  = 4'(c);
      #1;
      if (c >= 2) begin
        checks++; if (out_valid !== 1'b1 || out_tag !== 4'(c-2) ||
                      out_data !== (((c-2) % 2 == 1) ? beat_in(c-2) : beat_out(c-2))) begin
          errors++; $display("FAIL inv_mode cyc=%0d got v=%b d=%h", c, out_valid, out_data); end
        checks++; if (out_data1 !== (((c-2) % 2 == 1) ? vin(c-2) : vout(c-2))) begin
          errors++; $display("FAIL inv_lane1 cyc=%0d got %h want %h", c, out_data1,
                             (((c-2) % 2 == 1) ? vin(c-2) : vout(c-2))); end
      end
      tick();
    end
    in_valid = 1'b0; in_inv = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fwd_lane1();
    test_fwd_lanes4();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
`ifdef AES_INV_MIX_EN
    test_inverse();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_mixcol_pipe.md
Name: aes_mixcol_pipe

Overview:
- Parametrised, pipelined AES MixColumns datapath. Processes LANES 32-bit state columns per beat.
- Generalises the fixed single-output combinational cones used in the AES core into a registered multi-lane unit.
- Valid/ready handshake and a fixed 2-cycle latency.
- Sits between ShiftRows and AddRoundKey in the round pipeline.

Parameters:
- LANES, 4, number of 32-bit columns processed per beat (1..4).
- TAG_W, 4, width of the sideband tag carried alongside the data (e.g. round index).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_data  in  32*LANES  columns; column k = bits [32k+31:32k]; byte j of a column = bits [8j+7:8j] (a0 = LSB byte).
- in_tag  in  TAG_W  sideband, passed through unchanged.
- in_inv  in  1  1 = InvMixColumns. Port exists only when AES_INV_MIX_EN is defined.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  32*LANES  transformed columns, same layout as in_data.
- out_tag  out  TAG_W  tag of the beat on out_data.

Behaviour:
- Reset (clk, rst): sync active-high. All stage valid bits clear, so out_valid=0 and in_ready=1 in the first cycle after reset. out_data and out_tag = 0 at reset. Asserting rst mid-operation discards every in-flight beat; none is emitted after reset.
- Transfer rules: input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Pipeline: two register stages, S1 and S2.
  - S1 captures the input bytes plus the xtime products of each byte.
  - S2 holds the final result and drives out_data, out_tag and out_valid.
- Latency: 2 cycles from input transfer to out_valid, given no backpressure.
- Stage advance:
  - S2 loads from S1 when S1 is valid and (S2 is empty or S2 transfers this cycle).
  - S1 loads when (S1 is empty or S1 advances).
  - in_ready = !s1_valid | s1_advance. in_ready is combinational from out_ready; this path is permitted.
- Throughput: 1 beat per cycle when out_ready stays high.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_tag must hold stable. Up to 2 beats are buffered. No beat is dropped or duplicated.
- Simultaneous input and output transfer on a full pipe: both happen; occupancy is unchanged.
- Forward transform per column, with b0..b3 from a0..a3:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- GF(2^8) arithmetic:
  - xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1B : 0).
  - 3x = xtime(x)^x.
  - All arithmetic is 8-bit; no carries cross byte boundaries.
- Lane independence: lanes are processed independently and identically. in_tag is delayed exactly with its data.

Optional Feature:
- Macro: AES_INV_MIX_EN.
- When defined:
  - in_inv port exists and is registered with the beat.
  - in_inv=1 selects InvMixColumns: b0 = 0e·a0^0b·a1^0d·a2^09·a3, with the coefficients rotated for b1..b3.
  - Products are built from the chained xtime terms x2, x4, x8. Latency stays 2 cycles.
  - Mode may change on every beat.
- When undefined: the in_inv port is absent, only the forward transform is built, and the inverse logic must not be synthesised.

Test Plan:
- Forward known vector, LANES=1: in_data=32'h455313DB -> out_data=32'hBCA14D8E, 2 cycles after the transfer.
- Forward, LANES=4:
  - Input columns {32'h01010101, 32'hC6C6C6C6, 32'h5C220AF2, 32'h455313DB}.
  - Output columns {32'h01010101, 32'hC6C6C6C6, 32'h9D58DC9F, 32'hBCA14D8E}.
  - in_tag=4'hA must emerge with the beat.
- Streaming: 8 back-to-back beats with out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 2, in order, with in_ready never low.
- Backpressure:
  - out_ready=0 for 5 cycles while 3 beats are offered -> in_ready drops after 2 beats are accepted, and out_data stays stable.
  - On release, all 3 beats emerge in order, with no loss or duplication.
- Reset mid-flight: 2 beats in the pipe, then rst for 1 cycle -> out_valid=0 and out_data=0 the next cycle; no stale beat appears afterwards.
- With AES_INV_MIX_EN:
  - in_inv=1, in_data=32'hBCA14D8E -> 32'h455313DB.
  - Alternating in_inv on consecutive beats produces correct per-beat modes.
